// File: rtl/decryption_unit.sv
// decryption_unit: toy lattice decryption over Z_17[x]/(x^4+1).
// It computes w = v - s*u (a dot product of 2 polynomials) and then rounds
// each coefficient of w to one message bit.
// Optional feature: define DECRYPTION_COEF_OUT_EN to add the coef_out port.
// coef_out exposes w[0..3] and is updated together with message.
// Timing: the start edge latches the operands. MAC then runs for 33 cycles.
// That is 32 issued products plus one cycle to drain the product register.
// SUB follows for 1 cycle and DECODE for 1 cycle.
// done is the DECODE cycle, which comes after the 34th edge following start.
module decryption_unit (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] secretkey,
  input  logic [255:0] u,
  input  logic [127:0] v,
  output logic         busy,
  output logic         done,
  output logic [3:0]   message
`ifdef DECRYPTION_COEF_OUT_EN
  ,
  output logic [19:0]  coef_out
`endif
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    SUB    = 2'd2,
    DECODE = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_nextState;

  logic [4:0] r_s   [2][4];
  logic [4:0] r_u   [2][4];
  logic [4:0] r_v   [4];
  logic [4:0] r_acc [4];
  logic [4:0] r_w   [4];
  logic [4:0] r_cnt;
  logic       r_issuedAll;
  logic       r_pValid;
  logic [4:0] r_prod;
  logic [1:0] r_pIdx;
  logic       r_pNeg;
  logic [3:0] r_message;
`ifdef DECRYPTION_COEF_OUT_EN
  logic [19:0] r_coef;
`endif

  logic       w_i;
  logic [1:0] w_j;
  logic [1:0] w_k;
  logic [2:0] w_sumIdx;
  logic [4:0] w_prod;
  logic [4:0] w_wNext [4];
  logic [3:0] w_msgNext;

  // Reduce an arbitrary 32-bit operand into [0,16].
  function automatic logic [4:0] mod17(input logic [31:0] x);
    return 5'(x % 32'd17);
  endfunction

  // Multiply two residues mod 17.
  function automatic logic [4:0] mulMod17(input logic [4:0] a, input logic [4:0] b);
    logic [9:0] prod;
    prod = {5'b0, a} * {5'b0, b};
    return 5'(prod % 10'd17);
  endfunction

  // Add two residues mod 17; b may be 17 (used by subtraction when subtrahend is 0).
  function automatic logic [4:0] addMod17(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 6'd17) sum = sum - 6'd17;
    return sum[4:0];
  endfunction

  // Subtract two residues mod 17 without going negative.
  function automatic logic [4:0] subMod17(input logic [4:0] a, input logic [4:0] b);
    return addMod17(a, 5'd17 - b);
  endfunction

  // Decode the step counter as {i,j,k}, form the product and its target coefficient.
  always_comb begin
    w_i      = r_cnt[4];
    w_j      = r_cnt[3:2];
    w_k      = r_cnt[1:0];
    w_sumIdx = {1'b0, w_j} + {1'b0, w_k};
    w_prod   = mulMod17(r_s[w_i][w_j], r_u[w_i][w_k]);
  end

  // Compute w = v - acc and round each coefficient to a message bit.
  always_comb begin
    for (int n = 0; n < 4; n++) begin
      w_wNext[n]   = subMod17(r_v[n], r_acc[n]);
      w_msgNext[n] = (w_wNext[n] >= 5'd5) && (w_wNext[n] <= 5'd12);
    end
  end

  // Hold the state register; an asynchronous reset returns the machine to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Compute the next state and the status outputs.
  always_comb begin
    w_nextState = r_state;
    busy        = (r_state != IDLE);
    done        = (r_state == DECODE);
    case (r_state)
      IDLE:    if (start) w_nextState = MAC;
      MAC:     if (r_issuedAll) w_nextState = SUB;
      SUB:     w_nextState = DECODE;
      DECODE:  w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Datapath: latch operands, run the pipelined negacyclic MAC, subtract and round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        for (int j = 0; j < 4; j++) begin
          r_s[i][j] <= '0;
          r_u[i][j] <= '0;
        end
      end
      for (int n = 0; n < 4; n++) begin
        r_v[n]   <= '0;
        r_acc[n] <= '0;
        r_w[n]   <= '0;
      end
      r_cnt       <= '0;
      r_issuedAll <= 1'b0;
      r_pValid    <= 1'b0;
      r_prod      <= '0;
      r_pIdx      <= '0;
      r_pNeg      <= 1'b0;
      r_message   <= '0;
`ifdef DECRYPTION_COEF_OUT_EN
      r_coef      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            for (int i = 0; i < 2; i++) begin
              for (int j = 0; j < 4; j++) begin
                r_s[i][j] <= mod17(secretkey[(i*4+j)*32 +: 32]);
                r_u[i][j] <= mod17(u[(i*4+j)*32 +: 32]);
              end
            end
            for (int n = 0; n < 4; n++) begin
              r_v[n]   <= mod17(v[n*32 +: 32]);
              r_acc[n] <= '0;
            end
            r_cnt       <= '0;
            r_issuedAll <= 1'b0;
            r_pValid    <= 1'b0;
          end
        end
        MAC: begin
          if (r_pValid) begin
            if (r_pNeg) r_acc[r_pIdx] <= subMod17(r_acc[r_pIdx], r_prod);
            else        r_acc[r_pIdx] <= addMod17(r_acc[r_pIdx], r_prod);
          end
          if (!r_issuedAll) begin
            r_prod      <= w_prod;
            r_pIdx      <= w_sumIdx[1:0];
            r_pNeg      <= w_sumIdx[2];
            r_pValid    <= 1'b1;
            r_cnt       <= r_cnt + 5'd1;
            r_issuedAll <= (r_cnt == 5'd31);
          end else begin
            r_pValid <= 1'b0;
          end
        end
        SUB: begin
          for (int n = 0; n < 4; n++) r_w[n] <= w_wNext[n];
          r_message <= w_msgNext;
`ifdef DECRYPTION_COEF_OUT_EN
          r_coef    <= {w_wNext[3], w_wNext[2], w_wNext[1], w_wNext[0]};
`endif
        end
        default: begin
        end
      endcase
    end
  end

  assign message = r_message;
`ifdef DECRYPTION_COEF_OUT_EN
  assign coef_out = r_coef;
`endif

endmodule

// File: tb/tb_decryption_unit.sv
// Directed testbench for decryption_unit.
// Every expected message and coefficient value below was worked out by hand.
// The coef_out checks are compiled in only when DECRYPTION_COEF_OUT_EN is defined.
module tb_decryption_unit;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] secretkey;
  logic [255:0] u;
  logic [127:0] v;
  logic         busy;
  logic         done;
  logic [3:0]   message;
`ifdef DECRYPTION_COEF_OUT_EN
  logic [19:0]  coef_out;
`endif

  int nChecks = 0;
  int nPass   = 0;

  decryption_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .secretkey (secretkey),
    .u         (u),
    .v         (v),
    .busy      (busy),
    .done      (done),
    .message   (message)
`ifdef DECRYPTION_COEF_OUT_EN
    ,
    .coef_out  (coef_out)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  function automatic logic [127:0] pack4(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [19:0] coef4(input logic [4:0] w0, input logic [4:0] w1,
                                        input logic [4:0] w2, input logic [4:0] w3);
    return {w3, w2, w1, w0};
  endfunction

  // Start one operation, scramble the inputs while busy, and check timing and result.
  task automatic runOperation(input string name, input logic [255:0] sk, input logic [255:0] uu,
                              input logic [127:0] vv, input logic [3:0] expMsg,
                              input logic [19:0] expCoef);
    int doneCycle;
    int doneCount;
    int busyCount;
    logic [3:0]  msgAtDone;
    logic [19:0] coefAtDone;
    @(posedge clk); #1;
    secretkey = sk; u = uu; v = vv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    secretkey = {8{$urandom}};
    u = {8{$urandom}};
    v = {4{$urandom}};
    doneCycle = -1; doneCount = 0; busyCount = 0; msgAtDone = '0; coefAtDone = '0;
    for (int c = 0; c < 38; c++) begin
      if (busy) busyCount++;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle = c;
          msgAtDone = message;
`ifdef DECRYPTION_COEF_OUT_EN
          coefAtDone = coef_out;
`endif
        end
      end
      @(posedge clk); #1;
    end
    nChecks++;
    if (doneCycle !== 34) $display("[TB] FAIL %s done_latency: got %0d expected 34", name, doneCycle);
    else nPass++;
    nChecks++;
    if (doneCount !== 1) $display("[TB] FAIL %s done_count: got %0d expected 1", name, doneCount);
    else nPass++;
    nChecks++;
    if (busyCount !== 35) $display("[TB] FAIL %s busy_cycles: got %0d expected 35", name, busyCount);
    else nPass++;
    nChecks++;
    if (msgAtDone !== expMsg) $display("[TB] FAIL %s message_at_done: got %b expected %b", name, msgAtDone, expMsg);
    else nPass++;
    nChecks++;
    if (message !== expMsg) $display("[TB] FAIL %s message_hold: got %b expected %b", name, message, expMsg);
    else nPass++;
`ifdef DECRYPTION_COEF_OUT_EN
    nChecks++;
    if (coefAtDone !== expCoef) $display("[TB] FAIL %s coef_out: got %h expected %h", name, coefAtDone, expCoef);
    else nPass++;
`else
    if (coefAtDone !== expCoef && expCoef === 20'hFFFFF) $display("[TB] note %s", name);
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; secretkey = '0; u = '0; v = '0;
    repeat (2) @(posedge clk);
    #1;
    nChecks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else nPass++;
    nChecks++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else nPass++;
    nChecks++;
    if (message !== 4'b0) $display("[TB] FAIL reset_message: got %b expected 0000", message); else nPass++;
`ifdef DECRYPTION_COEF_OUT_EN
    nChecks++;
    if (coef_out !== 20'h0) $display("[TB] FAIL reset_coef: got %h expected 0", coef_out); else nPass++;
`endif
    rst_n = 1'b1;
  endtask

  task automatic test_known_answer();
    runOperation("zero_key", '0, '0, pack4(9, 0, 9, 0), 4'b0101, coef4(9, 0, 9, 0));
  endtask

  task automatic test_identity();
    runOperation("identity", {128'h0, pack4(1, 0, 0, 0)}, {128'h0, pack4(1, 2, 3, 4)},
                 pack4(10, 10, 10, 10), 4'b1111, coef4(9, 8, 7, 6));
  endtask

  task automatic test_wrap();
    runOperation("wrap", {128'h0, pack4(0, 1, 0, 0)}, {128'h0, pack4(0, 0, 0, 1)},
                 pack4(8, 0, 0, 0), 4'b0001, coef4(9, 0, 0, 0));
  endtask

  task automatic test_reduction();
    runOperation("reduce_v", '0, '0, pack4(26, 17, 43, 0), 4'b0101, coef4(9, 0, 9, 0));
    runOperation("reduce_all", {pack4(0, 0, 0, 32'hFFFFFFFF), pack4(18, 0, 0, 0)},
                 {pack4(5, 5, 5, 5), pack4(18, 19, 20, 21)},
                 pack4(27, 44, 10, 32'hFFFFFFFF), 4'b0111, coef4(9, 8, 7, 13));
  endtask

  task automatic test_decode_boundary();
    runOperation("boundary", '0, '0, pack4(4, 5, 12, 13), 4'b0110, coef4(4, 5, 12, 13));
  endtask

  task automatic test_mixed();
    runOperation("mixed", {pack4(0, 0, 1, 0), pack4(2, 0, 0, 0)},
                 {pack4(0, 0, 3, 0), pack4(0, 5, 0, 0)},
                 pack4(0, 0, 0, 0), 4'b0010, coef4(3, 7, 0, 0));
  endtask

  task automatic test_ignore_start();
    int doneCycle;
    int doneCount;
    @(posedge clk); #1;
    secretkey = {128'h0, pack4(0, 1, 0, 0)}; u = {128'h0, pack4(0, 0, 0, 1)};
    v = pack4(8, 0, 0, 0); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    doneCycle = -1; doneCount = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin
        doneCount++;
        if (doneCycle < 0) doneCycle = c;
      end
      start = (c == 3 || c == 20);
      @(posedge clk); #1;
    end
    start = 1'b0;
    nChecks++;
    if (doneCycle !== 34) $display("[TB] FAIL ignore_start_latency: got %0d expected 34", doneCycle); else nPass++;
    nChecks++;
    if (doneCount !== 1) $display("[TB] FAIL ignore_start_count: got %0d expected 1", doneCount); else nPass++;
    nChecks++;
    if (busy !== 1'b0) $display("[TB] FAIL ignore_start_queued: busy %b expected 0", busy); else nPass++;
    nChecks++;
    if (message !== 4'b0001) $display("[TB] FAIL ignore_start_message: got %b expected 0001", message); else nPass++;
  endtask

  task automatic test_back_to_back();
    int firstDone;
    int secondDone;
    int doneCount;
    logic gapBusy;
    @(posedge clk); #1;
    secretkey = {128'h0, pack4(1, 0, 0, 0)}; u = {128'h0, pack4(1, 2, 3, 4)};
    v = pack4(10, 10, 10, 10); start = 1'b1;
    firstDone = -1; secondDone = -1; doneCount = 0; gapBusy = 1'b1;
    for (int c = 0; c < 72; c++) begin
      @(posedge clk); #1;
      if (done) begin
        doneCount++;
        if (firstDone < 0) firstDone = c;
        else if (secondDone < 0) secondDone = c;
      end
      if (c == 35) gapBusy = busy;
    end
    start = 1'b0;
    nChecks++;
    if (firstDone !== 34) $display("[TB] FAIL b2b_first_done: got %0d expected 34", firstDone); else nPass++;
    nChecks++;
    if (secondDone !== 70) $display("[TB] FAIL b2b_second_done: got %0d expected 70", secondDone); else nPass++;
    nChecks++;
    if (doneCount !== 2) $display("[TB] FAIL b2b_done_count: got %0d expected 2", doneCount); else nPass++;
    nChecks++;
    if (gapBusy !== 1'b0) $display("[TB] FAIL b2b_idle_gap: busy %b expected 0", gapBusy); else nPass++;
    nChecks++;
    if (message !== 4'b1111) $display("[TB] FAIL b2b_message: got %b expected 1111", message); else nPass++;
    @(posedge clk); #1;
    nChecks++;
    if (busy !== 1'b0) $display("[TB] FAIL b2b_stop: busy %b expected 0", busy); else nPass++;
  endtask

  task automatic test_reset_mid();
    int doneCount;
    int busyCount;
    @(posedge clk); #1;
    secretkey = '0; u = '0; v = pack4(9, 0, 9, 0); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    nChecks++;
    if (busy !== 1'b0) $display("[TB] FAIL midreset_busy: got %b expected 0", busy); else nPass++;
    nChecks++;
    if (message !== 4'b0) $display("[TB] FAIL midreset_message: got %b expected 0000", message); else nPass++;
    nChecks++;
    if (done !== 1'b0) $display("[TB] FAIL midreset_done: got %b expected 0", done); else nPass++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    doneCount = 0; busyCount = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) doneCount++;
      if (busy) busyCount++;
    end
    nChecks++;
    if (doneCount !== 0) $display("[TB] FAIL midreset_no_done: got %0d expected 0", doneCount); else nPass++;
    nChecks++;
    if (busyCount !== 0) $display("[TB] FAIL midreset_idle: busy cycles %0d expected 0", busyCount); else nPass++;
    runOperation("after_reset", {128'h0, pack4(1, 0, 0, 0)}, {128'h0, pack4(1, 2, 3, 4)},
                 pack4(10, 10, 10, 10), 4'b1111, coef4(9, 8, 7, 6));
  endtask

  // Run every scenario in order and print the summary.
  initial begin
    $display("[TB] decryption_unit test start");
    test_reset();
    test_known_answer();
    test_identity();
    test_wrap();
    test_reduction();
    test_decode_boundary();
    test_mixed();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/decryption_unit.md
DECRYPTION_UNIT -- requirements
Module: decryption_unit

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: start  input  1  request to decrypt; sampled only in IDLE.
REQ-004 SHALL: secretkey  input  2x4x32  secret vector s[i][j] (polynomial i, coefficient j).
REQ-005 SHALL: u  input  2x4x32  ciphertext vector u[i][j].
REQ-006 SHALL: v  input  4x32  ciphertext polynomial v[n].
REQ-007 SHALL: busy  output  1  high while an operation is in progress (state not IDLE).
REQ-008 SHALL: done  output  1  one-cycle pulse; message is valid from this cycle.
REQ-009 SHALL: message  output  4  recovered plaintext bits; bit n comes from coefficient n.

Function
REQ-010 SHALL: ring is Z_17[x]/(x^4+1); every stored coefficient lies in [0,16].
REQ-011 SHALL: on the edge where start=1 in IDLE, latch s, u and v, each reduced as (unsigned value mod 17); clear acc[0..3] and cnt; go to MAC.
REQ-012 SHALL: inputs are not sampled outside that edge; they may change freely while busy.
REQ-013 SHALL: FSM states are IDLE, MAC, SUB, DECODE; transitions are IDLE->MAC on start, MAC->SUB after 32 steps, SUB->DECODE, DECODE->IDLE.
REQ-014 SHALL: MAC performs one product per cycle, 32 cycles total; the 5-bit cnt decodes as {i,j,k} (i MSB, k LSB).
REQ-015 SHALL: each MAC step is p = s[i][j]*u[i][k] mod 17; if j+k<4 then acc[j+k] = (acc[j+k]+p) mod 17, else acc[j+k-4] = (acc[j+k-4]+17-p) mod 17 (negacyclic wrap).
REQ-016 SHALL: in SUB, compute w[n] = (v[n]+17-acc[n]) mod 17 into registers.
REQ-017 SHALL: in DECODE, set message[n] = 1 iff 5 <= w[n] <= 12, else 0, and assert done for exactly that cycle.
REQ-018 SHALL: latency is fixed: done is high in the cycle after the 34th rising edge following the start-sampling edge, independent of data.
REQ-019 SHALL: start asserted while busy=1 is ignored and not queued.
REQ-020 SHALL: start held high continuously starts a new operation on the first IDLE edge after done.
REQ-021 SHALL: message holds its value from done until the next done or reset.

Reset
REQ-022 SHALL: rst_n=0 immediately forces state IDLE, busy=0, done=0, message=0, and clears acc, w, cnt and the latched operands to 0.
REQ-023 SHALL: reset asserted mid-operation aborts the operation; no done is produced for it.
REQ-024 SHALL: the first start after reset release is accepted normally.

Configuration
REQ-025 SHALL: macro DECRYPTION_COEF_OUT_EN, when defined, adds output coef_out (4x5), holding w[0..3], updated together with message at done and reset to 0.
REQ-026 SHALL: when DECRYPTION_COEF_OUT_EN is undefined, coef_out does not exist and all other behaviour is identical.

Verification
REQ-027 SHALL: s=0, u=0, v={9,0,9,0}, start pulse -> done 34 cycles later, message=4'b0101, busy high for 35 cycles.
REQ-028 SHALL: s[0]={1,0,0,0}, s[1]=0, u[0]={1,2,3,4}, u[1]=0, v={10,10,10,10} -> w={9,8,7,6}, message=4'b1111, coef_out={9,8,7,6} when macro defined.
REQ-029 SHALL: s[0]={0,1,0,0}, u[0]={0,0,0,1}, other polynomials 0, v={8,0,0,0} -> acc[0]=16 via wrap, w[0]=9, message=4'b0001.
REQ-030 SHALL: s=0, u=0, v={26,17,43,0} -> reduced v={9,0,9,0}, message=4'b0101.
REQ-031 SHALL: extra start pulses at cycles 3 and 20 of an operation -> ignored; exactly one done at cycle 34.
REQ-032 SHALL: rst_n low at cycle 10 of an operation -> busy=0 and message=0 at once, no done; a later start completes correctly.
